mult_unit: RTL

Iterative 32x32 multiplier that executes the MULT-class instructions issued by the multicycle main controller. The controller pulses start with the two register-file operands. The unit computes a 64-bit product over WIDTH shift-add cycles and raises a one-cycle done pulse. The controller then writes result_lo (and result_hi for HI/LO-style ops) back through the ALU result path.

---
 rtl/mult_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT-class instructions: one radix-2 step per
// cycle over WIDTH cycles, a sign-fix cycle, then a one-cycle done pulse.
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;
    logic                 accept;

    // The most-negative value maps onto itself, which reads correctly as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
    assign prod   = apply_sign(acc_q, neg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (accept) begin
            mcand_d = abs_val(op_a, signed_mode);
            mplr_d  = abs_val(op_b, signed_mode);
            neg_d   = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
        end else if (state_q == RUN) begin
            // Carry out of the upper-half add lands in the top bit after the shift.
            acc_d  = {sum, acc_q[WIDTH-1:1]};
            mplr_d = mplr_q >> 1;
            cnt_d  = cnt_q - CNT_W'(1);
        end else if (state_q == FIX) begin
            lo_d   = prod[WIDTH-1:0];
            hi_d   = prod[2*WIDTH-1:WIDTH];
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;

endmodule
